// File: rtl/ir_decode_stage.sv
// Instruction register, fetch-PC latch and MDR for the 16-bit multi-cycle core.
// Presents the FSM control word, register indices and sign-extended immediate.
module ir_decode_stage #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IRWrite,
    input  logic             MemR,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] pc_in,
    output logic [6:0]       control_word,
    output logic [2:0]       rd,
    output logic [2:0]       rs1,
    output logic [2:0]       rs2,
    output logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] old_pc,
    output logic [WIDTH-1:0] mdr,
    output logic             instr_valid,
    output logic             illegal_op
);

    logic [15:0] ir;
    logic [2:0]  opcode;
    logic [6:0]  f7_hi;
    logic [6:0]  f7_split;
    logic [9:0]  f10;

    // Instruction register, its PC and the valid flag load together on IRWrite
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ir          <= '0;
            old_pc      <= '0;
            instr_valid <= 1'b0;
        end else if (IRWrite) begin
            ir          <= mem_rdata;
            old_pc      <= pc_in;
            instr_valid <= 1'b1;
        end
    end

    // Memory data register, independent of IRWrite
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mdr <= '0;
        end else if (MemR) begin
            mdr <= mem_rdata;
        end
    end

    assign opcode       = ir[2:0];
    assign control_word = {ir[15:12], ir[2:0]};
    assign rd           = ir[5:3];
    assign rs1          = ir[8:6];
    assign rs2          = ir[11:9];
    assign f7_hi        = ir[15:9];
    assign f7_split     = {ir[15:12], ir[5:3]};
    assign f10          = ir[15:6];
    assign illegal_op   = instr_valid && (opcode == 3'd7);

    // Immediate format chosen by opcode; branch/jump offsets are halfword scaled
    always_comb begin
        imm = '0;
        unique case (opcode)
            3'd0: imm = '0;
            3'd1: imm = {{9{f7_hi[6]}}, f7_hi};
            3'd2: imm = {{9{f7_hi[6]}}, f7_hi};
            3'd3: imm = {{9{f7_split[6]}}, f7_split};
            3'd4: imm = {{8{f7_split[6]}}, f7_split, 1'b0};
            3'd5: imm = {{9{f7_hi[6]}}, f7_hi};
            3'd6: imm = {{5{f10[9]}}, f10, 1'b0};
            3'd7: imm = '0;
            default: imm = '0;
        endcase
    end

endmodule

// File: tb/tb_ir_decode_stage.sv
// Directed self-checking bench for ir_decode_stage.
// Expected values are hand-decoded from each instruction word.
module tb_ir_decode_stage;

    logic        CLK;
    logic        Reset;
    logic        IRWrite;
    logic        MemR;
    logic [15:0] mem_rdata;
    logic [15:0] pc_in;
    logic [6:0]  control_word;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] old_pc;
    logic [15:0] mdr;
    logic        instr_valid;
    logic        illegal_op;

    int n_chk;
    int n_fail;

    ir_decode_stage #(.WIDTH(16)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .IRWrite(IRWrite),
        .MemR(MemR),
        .mem_rdata(mem_rdata),
        .pc_in(pc_in),
        .control_word(control_word),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .imm(imm),
        .old_pc(old_pc),
        .mdr(mdr),
        .instr_valid(instr_valid),
        .illegal_op(illegal_op)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given strobes; inputs change on the falling edge
    task automatic cyc(input logic irw, input logic mr,
                       input logic [15:0] data, input logic [15:0] pc);
        @(negedge CLK);
        IRWrite   = irw;
        MemR      = mr;
        mem_rdata = data;
        pc_in     = pc;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        IRWrite = 1'b0;
        MemR    = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        Reset     = 1'b1;
        IRWrite   = 1'b0;
        MemR      = 1'b0;
        mem_rdata = 16'h0;
        pc_in     = 16'h0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        cyc(1'b0, 1'b0, 16'hAAAA, 16'h1111);
        chk("rst_cw", {9'd0, control_word}, 16'h0000);
        chk("rst_fields", {7'd0, rd, rs1, rs2}, 16'h0000);
        chk("rst_imm", imm, 16'h0000);
        chk("rst_oldpc", old_pc, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        chk("rst_flags", {14'd0, instr_valid, illegal_op}, 16'h0000);

        // Async reset with no edge
        cyc(1'b1, 1'b1, 16'hFFFF, 16'h2222);
        chk("ffff_cw", {9'd0, control_word}, 16'h007F);
        chk("ffff_illegal", {15'd0, illegal_op}, 16'h0001);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_cw", {9'd0, control_word}, 16'h0000);
        chk("async_oldpc", old_pc, 16'h0000);
        chk("async_mdr", mdr, 16'h0000);
        chk("async_flags", {14'd0, instr_valid, illegal_op}, 16'h0000);

        // Reset held across an IRWrite/MemR edge: no load
        cyc(1'b1, 1'b1, 16'h5555, 16'h3333);
        chk("rstwin_cw", {9'd0, control_word}, 16'h0000);
        chk("rstwin_mdr", mdr, 16'h0000);
        chk("rstwin_valid", {15'd0, instr_valid}, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;

        // R3 instruction
        cyc(1'b1, 1'b0, 16'h5A88, 16'h0040);
        chk("r3_cw", {9'd0, control_word}, 16'h0028);
        chk("r3_rd", {13'd0, rd}, 16'h0001);
        chk("r3_rs1", {13'd0, rs1}, 16'h0002);
        chk("r3_rs2", {13'd0, rs2}, 16'h0005);
        chk("r3_imm", imm, 16'h0000);
        chk("r3_oldpc", old_pc, 16'h0040);
        chk("r3_valid", {15'd0, instr_valid}, 16'h0001);
        chk("r3_illegal", {15'd0, illegal_op}, 16'h0000);

        // IR holds while IRWrite is low, even as mem_rdata changes
        cyc(1'b0, 1'b0, 16'hFFFF, 16'h9999);
        chk("hold_cw", {9'd0, control_word}, 16'h0028);
        chk("hold_oldpc", old_pc, 16'h0040);

        // RI
        cyc(1'b1, 1'b0, 16'hFE49, 16'h0042);
        chk("ri_imm", imm, 16'hFFFF);
        chk("ri_rd", {13'd0, rd}, 16'h0001);
        chk("ri_rs1", {13'd0, rs1}, 16'h0001);
        chk("ri_oldpc", old_pc, 16'h0042);

        // LW
        cyc(1'b1, 1'b0, 16'h7E4A, 16'h0044);
        chk("lw_imm", imm, 16'h003F);

        // SW: field {0111,001}
        cyc(1'b1, 1'b0, 16'h700B, 16'h0046);
        chk("sw_imm", imm, 16'h0039);

        // BR negative
        cyc(1'b1, 1'b0, 16'hF03C, 16'h0048);
        chk("br_imm", imm, 16'hFFFE);

        // JALR: field 7'b0000001
        cyc(1'b1, 1'b0, 16'h0205, 16'h004A);
        chk("jalr_imm", imm, 16'h0001);

        // JAL
        cyc(1'b1, 1'b0, 16'h8006, 16'h004C);
        chk("jal_imm", imm, 16'hFC00);

        // Illegal opcode
        cyc(1'b1, 1'b0, 16'h0007, 16'h004E);
        chk("ill_flag", {15'd0, illegal_op}, 16'h0001);
        chk("ill_imm", imm, 16'h0000);
        chk("ill_cw", {9'd0, control_word}, 16'h0007);

        // MemR alone
        cyc(1'b0, 1'b1, 16'hBEEF, 16'h0050);
        chk("memr_mdr", mdr, 16'hBEEF);
        chk("memr_ir_cw", {9'd0, control_word}, 16'h0007);
        chk("memr_oldpc", old_pc, 16'h004E);

        // MDR holds without MemR
        cyc(1'b0, 1'b0, 16'h0BAD, 16'h0052);
        chk("mdr_hold", mdr, 16'hBEEF);

        // Both strobes: BR with field {0001,110}
        cyc(1'b1, 1'b1, 16'h1234, 16'h0054);
        chk("both_mdr", mdr, 16'h1234);
        chk("both_cw", {9'd0, control_word}, 16'h000C);
        chk("both_imm", imm, 16'h001C);
        chk("both_oldpc", old_pc, 16'h0054);
        chk("both_illegal", {15'd0, illegal_op}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
